// File: rtl/down_count_ctrl.sv
// down_count_ctrl: down-counter with one-shot/periodic modes, pause and abort.
// A run loads load_val, counts down once per unpaused cycle and pulses done
// at terminal count. It then reloads in periodic mode or returns to IDLE in
// one-shot mode. All outputs are registered.
module down_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [WIDTH-1:0] reload_r;
  logic             mode_r;

  logic [1:0]       state_s;
  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] reload_s;
  logic             mode_s;
  logic             done_s;
  logic             busy_s;
  logic             paused_s;

  // Next-state and next-output decode; abort outranks pause, pause outranks counting.
  always_comb begin
    state_s  = state_r;
    count_s  = count;
    reload_s = reload_r;
    mode_s   = mode_r;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          if (load_val != CNT_ZERO) begin
            state_s  = ST_RUN;
            count_s  = load_val;
            reload_s = load_val;
            mode_s   = auto_reload;
          end else begin
            // A zero-length period terminates immediately without ever going busy.
            count_s = CNT_ZERO;
            done_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (abort) begin
          state_s = ST_IDLE;
          count_s = CNT_ZERO;
        end else if (pause) begin
          state_s = ST_HOLD;
        end else if (count > CNT_ONE) begin
          state_s = ST_RUN;
          count_s = count - CNT_ONE;
        end else if (mode_r) begin
          // Terminal count in periodic mode: reload instead of stepping to zero.
          state_s = ST_RUN;
          count_s = reload_r;
          done_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
          count_s = CNT_ZERO;
          done_s  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = CNT_ZERO;
      end
    endcase
    busy_s   = (state_s != ST_IDLE);
    paused_s = (state_s == ST_HOLD);
  end

  // State, configuration and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      reload_r <= CNT_ZERO;
      mode_r   <= 1'b0;
      count    <= CNT_ZERO;
      busy     <= 1'b0;
      paused   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_s;
      reload_r <= reload_s;
      mode_r   <= mode_s;
      count    <= count_s;
      busy     <= busy_s;
      paused   <= paused_s;
      done     <= done_s;
    end
  end

endmodule

// File: tb/tb_down_count_ctrl.sv
// tb_down_count_ctrl: directed vectors with a scoreboard queue. The driver
// pushes the expected post-edge outputs for every cycle it drives, and a
// monitor pops and compares one entry after each rising edge.
module tb_down_count_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] load_val;
  logic       auto_reload;
  logic       pause;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       paused;
  logic       done;

  typedef struct {
    logic [3:0] count;
    logic       busy;
    logic       paused;
    logic       done;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  down_count_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .pause       (pause),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .paused      (paused),
    .done        (done)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_field(input string name, input string field, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", name, field, act, req);
    end
  endtask

  task automatic check_now(input string name, input logic [3:0] ec, input logic eb,
                           input logic ep, input logic ed);
    check_field(name, "count", int'(count), int'(ec));
    check_field(name, "busy", int'(busy), int'(eb));
    check_field(name, "paused", int'(paused), int'(ep));
    check_field(name, "done", int'(done), int'(ed));
  endtask

  // Apply inputs for one cycle and queue the outputs expected after the edge.
  task automatic step(input string name, input logic s, input logic [3:0] lv, input logic ar,
                      input logic p, input logic ab, input logic [3:0] ec, input logic eb,
                      input logic ep, input logic ed);
    exp_t e;
    start       = s;
    load_val    = lv;
    auto_reload = ar;
    pause       = p;
    abort       = ab;
    e.count  = ec;
    e.busy   = eb;
    e.paused = ep;
    e.done   = ed;
    e.name   = name;
    exp_q.push_back(e);
    @(posedge clk);
    #3;
  endtask

  // Monitor: one scoreboard entry is consumed shortly after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_now(e.name, e.count, e.busy, e.paused, e.done);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; start = 1'b0; load_val = 4'd0; auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
    #1;
    check_now("reset_async", 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    check_now("reset_clocked", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // One-shot from 3; mid-run start/load_val/auto_reload changes are ignored.
    step("os_load",  1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    step("os_2",     1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    step("os_1",     1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    step("os_done",  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step("os_idle",  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Periodic from 2, then abort together with pause at count 2.
    step("per_load", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    step("per_1a",   1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    step("per_rl_a", 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1);
    step("per_1b",   1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    step("per_rl_b", 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1);
    step("abort_pz", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step("idle_sa",  1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step("idle_sa2", 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Pause for 3 cycles at count 3: done arrives 3 cycles late.
    step("pz_load",  1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
    step("pz_3",     1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("pz_hold", 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
    step("pz_2",     1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    step("pz_1",     1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    step("pz_done",  1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Abort from HOLD in periodic mode.
    step("ha_load",  1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
    step("ha_hold",  1'b0, 4'd6, 1'b1, 1'b1, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0);
    step("ha_abort", 1'b0, 4'd6, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

    // load_val = 0: single done pulse, never busy.
    step("zero_st",  1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step("zero_aft", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // load_val = 15: 15 cycles to done, no wrap.
    step("max_load", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
    for (int v = 14; v >= 1; v--)
      step("max_cnt", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 4'(v), 1'b1, 1'b0, 1'b0);
    step("max_done", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step("max_idle", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run between clock edges.
    step("ar_load",  1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
    step("ar_4",     1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check_now("ar_async", 4'd0, 1'b0, 1'b0, 1'b0);
    step("ar_held",  1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step("ar_held2", 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step("ar_rs_ld", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    step("ar_rs_1",  1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    step("ar_rs_dn", 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    @(posedge clk);
    #2;
    check_field("scoreboard_drain", "pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
